fa_resp_checker: RTL

FA_RESP_CHECKER -- requirements
Module: fa_resp_checker

---
 rtl/fa_chk_pkg.sv | 21 ++
 rtl/fa_golden_model.sv | 13 +
 rtl/fa_resp_checker.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fa_chk_pkg.sv
// Shared types and constants for the full-adder response checker.
package fa_chk_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [7:0] COV_FULL = 8'hFF;

    // Field order matches the first_err port: {a,b,cin,sout,cout}.
    typedef struct packed {
        logic a;
        logic b;
        logic cin;
        logic sout;
        logic cout;
    } first_err_t;

endpackage

// File: rtl/fa_golden_model.sv
// Reference full adder producing the expected sum and carry for one sample.
module fa_golden_model (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic exp_s,
    output logic exp_c
);

    assign exp_s = a ^ b ^ cin;
    assign exp_c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_resp_checker.sv
// Checks observed full-adder responses against a golden model, tracking
// input coverage, mismatch count, the first failing sample and an idle timeout.
import fa_chk_pkg::*;

module fa_resp_checker #(
    parameter int unsigned ERR_W = 8,
    parameter int unsigned TMO   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             sout,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       cov_map,
    output logic [4:0]       first_err,
    output logic             first_err_vld
);

    localparam int unsigned IDLE_W = $clog2(TMO + 1);

    state_t            state_q;
    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;
    logic [7:0]        cov_d;
    logic [ERR_W-1:0]  err_d;
    logic              mismatch;
    logic              exp_s;
    logic              exp_c;
    first_err_t        fe_d;

    fa_golden_model u_golden (
        .a     (a),
        .b     (b),
        .cin   (cin),
        .exp_s (exp_s),
        .exp_c (exp_c)
    );

    always_comb begin
        mismatch = {sout, cout} != {exp_s, exp_c};
        cov_d    = cov_map | (8'b1 << {a, b, cin});
        err_d    = (mismatch && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;
        idle_d   = idle_q + 1'b1;
        fe_d     = '{a: a, b: b, cin: cin, sout: sout, cout: cout};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idle_q        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_cnt       <= '0;
            cov_map       <= '0;
            first_err     <= '0;
            first_err_vld <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q       <= S_RUN;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        idle_q        <= '0;
                        pass          <= 1'b0;
                        timeout       <= 1'b0;
                        err_cnt       <= '0;
                        cov_map       <= '0;
                        first_err     <= '0;
                        first_err_vld <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (valid) begin
                        idle_q  <= '0;
                        cov_map <= cov_d;
                        err_cnt <= err_d;
                        if (mismatch && !first_err_vld) begin
                            first_err     <= fe_d;
                            first_err_vld <= 1'b1;
                        end
                        // Completing sample's own mismatch is folded into pass via err_d.
                        if (cov_d == COV_FULL) begin
                            state_q <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_d == '0);
                            timeout <= 1'b0;
                        end
                    end else begin
                        idle_q <= idle_d;
                        if (idle_d == IDLE_W'(TMO)) begin
                            state_q <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= 1'b0;
                            timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
